run_length_decoder_moore: RTL and testbench
===========================================

RUN_LENGTH_DECODER_MOORE -- requirements
Module: run_length_decoder_moore

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clock  input  1  rising-edge clock, 156.25 MHz target.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dataIn  input  9  out_st encoded stream: data[7] indication, data[6:0] value or count, valid.
REQ-005 in_ready  output  1  high when the block accepts dataIn this cycle.
REQ-006 dataOut  output  8  decoded stream: data[6:0] symbol, valid.
REQ-007 proto_err  output  1  one-cycle pulse on a malformed run (count byte 0).

Function
REQ-008 A byte SHALL be accepted only in a cycle with dataIn.valid=1 and in_ready=1.
REQ-009 Stream format SHALL be fixed as follows.
- data[7]=0: literal, emitted once.
- data[7]=1: run header with value data[6:0].
- The next accepted byte after a header is the run length N, full 8 bits (1..255), with bit 7 not interpreted.
REQ-010 The FSM SHALL have four states: IDLE, LIT, HDR, RUN.
REQ-011 Outputs SHALL be Moore (a function of registered state only).
- dataOut.valid=1 in LIT and RUN, 0 in IDLE and HDR.
- dataOut.data = {1'b0, value register}.
REQ-012 in_ready SHALL be 1 in IDLE, LIT and HDR, and in RUN only when count==1.
REQ-013 From IDLE, LIT, or RUN with count==1, the FSM SHALL transition as follows.
- Accept literal: go to LIT, value<=data[6:0].
- Accept header: go to HDR, value<=data[6:0].
- No accept: go to IDLE.
REQ-014 From HDR, the FSM SHALL transition as follows.
- No accept: stay in HDR indefinitely.
- Accept N=0: go to IDLE, proto_err=1 next cycle, nothing emitted.
- Accept N=1: go to LIT.
- Accept N>=2: go to RUN with count<=N.
REQ-015 In RUN with count>1, count SHALL decrement by 1 per cycle while the state is held.
REQ-016 count SHALL be an 8-bit register and SHALL never wrap below 1 while in RUN.
REQ-017 Latency SHALL be fixed.
- Literal accepted at cycle t: output at t+1.
- Count byte accepted at t: N consecutive outputs at t+1..t+N.
REQ-018 Back-to-back literals and runs SHALL decode with no bubble cycles.
REQ-019 A header immediately following a run SHALL insert exactly one invalid cycle, in HDR.
REQ-020 The value register SHALL hold its contents in IDLE and HDR.
REQ-021 proto_err SHALL be a registered signal, high for exactly one cycle per violation.

Reset
REQ-022 While reset=1 at a rising clock edge, the block SHALL load these values on the next cycle:
- State=IDLE, count=0, value=0
- dataOut=0, proto_err=0, in_ready=1
REQ-023 Reset SHALL abort any run in progress (LIT, HDR or RUN), and remaining symbols SHALL be discarded.
REQ-024 A byte presented during the reset cycle SHALL be ignored.

Structure
REQ-025 Package rle_pkg SHALL hold the following shared definitions.
- out_st packed struct {logic [7:0] data; logic valid;}, shared with the encoder.
- Decoder state enum (IDLE, LIT, HDR, RUN), exposed as DUT.State.
- Constants: VALUE_W=7, COUNT_W=8.
REQ-026 The block SHALL be a single module with no sub-module; the next-state and output logic SHALL be separate always blocks.

Verification
REQ-027 Literal then run: 0x37 (v=1), header 0xCB, count 0x03 -> outputs 0x37, gap, 0x4B x3 on consecutive cycles.
REQ-028 Long run: header 0x88 with count 0xFF, then header 0x88 with count 0x0F.
- Required output: 255 + 15 = 270 outputs of 0x08, with one HDR gap between the two runs.
- in_ready=0 throughout the run except on each count==1 cycle.
REQ-029 Zero count: header 0x8E with count 0x00 -> proto_err high for exactly one cycle, no valid output, returns to IDLE.
REQ-030 Unit count and stall: header 0xEF, then dataIn.valid=0 for 5 cycles, then count 0x01.
- Required: the block stays in HDR for 5 cycles.
- Then a single 0x6F output.
REQ-031 Reset mid-run: reset=1 while RUN count=100 -> next cycle dataOut.valid=0, State=IDLE, in_ready=1; afterwards literal 0x58 decodes normally.
REQ-032 Continuous literals 0x01..0x0A with valid every cycle -> 10 outputs with no gaps, in_ready constantly 1.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length codec: the byte-plus-valid word
// exchanged between encoder and decoder, the decoder state encoding and
// the field widths used by both sides.
package rle_pkg;

   // Width of a symbol value carried in data[6:0]
   localparam int VALUE_W = 7;

   // Width of the run-length count byte
   localparam int COUNT_W = 8;

   // Stream word: one byte of payload plus its qualifier.
   // As a flat vector, valid sits in bit 0 and data in bits [8:1].
   typedef struct packed {
      logic [7:0] data;
      logic       valid;
   } out_st;

   // Decoder states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LIT  = 2'd1,
      HDR  = 2'd2,
      RUN  = 2'd3
   } state_t;

   // A byte with its top bit set announces a run; otherwise it is a literal
   function automatic logic is_header(input logic [7:0] b);
      return b[7];
   endfunction

endpackage

// File: rtl/run_length_decoder_moore.sv
// Moore-style run-length decoder.
//
// Input stream (dataIn, an out_st word): a byte with bit 7 clear is a
// literal and is emitted once. A byte with bit 7 set is a run header
// carrying the symbol in bits [6:0]. The next accepted byte is the run
// length N, taken as a full 8-bit count. A count of zero is malformed
// and raises proto_err for one cycle.
//
// Output word dataOut is the out_st layout without its always-zero data
// MSB: bits [7:1] hold the symbol, bit 0 is valid. Every output comes
// from registered state, so a symbol appears the cycle after the byte
// that produced it is accepted.
module run_length_decoder_moore
   import rle_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [8:0] dataIn,
   output logic       in_ready,
   output logic [7:0] dataOut,
   output logic       proto_err
);

   state_t               State;
   state_t               state_next;
   logic [COUNT_W-1:0]   count;
   logic [COUNT_W-1:0]   count_next;
   logic [VALUE_W-1:0]   value;
   logic [VALUE_W-1:0]   value_next;
   logic                 proto_err_next;

   out_st                in_word;
   logic                 accept;
   logic                 run_last;
   logic                 out_valid;

   assign in_word = dataIn;

   // Moore outputs and the handshake, all derived from registered state.
   // A run only frees the input on its final symbol, which lets the next
   // byte follow the run without a bubble.
   always_comb begin
      run_last  = (count == COUNT_W'(1));
      out_valid = (State == LIT) || (State == RUN);
      in_ready  = (State != RUN) || run_last;
      dataOut   = {value, out_valid};
      accept    = in_word.valid && in_ready;
   end

   // Next-state logic. HDR waits for the count byte. A run still counting
   // down only decrements. Every other case (IDLE, LIT, final run cycle)
   // is a slot where a fresh literal or header may be taken.
   always_comb begin
      state_next     = State;
      count_next     = count;
      value_next     = value;
      proto_err_next = 1'b0;

      if (State == HDR) begin
         if (accept) begin
            if (in_word.data == 8'd0) begin
               state_next     = IDLE;
               proto_err_next = 1'b1;
            end else if (in_word.data == 8'd1) begin
               state_next = LIT;
            end else begin
               state_next = RUN;
               count_next = in_word.data;
            end
         end
      end else if ((State == RUN) && !run_last) begin
         count_next = count - COUNT_W'(1);
      end else begin
         if (accept) begin
            value_next = in_word.data[VALUE_W-1:0];
            if (is_header(in_word.data)) begin
               state_next = HDR;
            end else begin
               state_next = LIT;
            end
         end else begin
            state_next = IDLE;
         end
      end
   end

   // State, counter, symbol and error registers with synchronous reset.
   // Reset drops any run in progress and ignores the byte on the bus.
   always_ff @(posedge clock) begin
      if (reset) begin
         State     <= IDLE;
         count     <= '0;
         value     <= '0;
         proto_err <= 1'b0;
      end else begin
         State     <= state_next;
         count     <= count_next;
         value     <= value_next;
         proto_err <= proto_err_next;
      end
   end

endmodule

// File: tb/tb_run_length_decoder_moore.sv
// Directed bench for the run-length decoder: a table of per-cycle vectors
// followed by hand-written long-run, reset-mid-run and literal-burst
// sequences. Outputs are sampled 1 ns after each rising edge.
module tb_run_length_decoder_moore;
   import rle_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [8:0] dataIn = '0;
   logic       in_ready;
   logic [7:0] dataOut;
   logic       proto_err;

   int checks = 0;
   int errors = 0;
   int valid_seen = 0;

   typedef struct {
      logic       rst;
      logic       vin;
      logic [7:0] b;
      logic       ev;
      logic [6:0] es;
      logic       er;
      logic       ee;
      state_t     st;
   } vec_t;

   vec_t vecs[27];

   run_length_decoder_moore dut (
      .clock     (clock),
      .reset     (reset),
      .dataIn    (dataIn),
      .in_ready  (in_ready),
      .dataOut   (dataOut),
      .proto_err (proto_err)
   );

   // 100 MHz-ish free-running clock
   always #5 clock = ~clock;

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic rst, input logic vin, input logic [7:0] b,
                               input logic ev, input logic [6:0] es, input logic er,
                               input logic ee, input state_t st);
      vec_t v;
      v.rst = rst; v.vin = vin; v.b = b;
      v.ev = ev; v.es = es; v.er = er; v.ee = ee; v.st = st;
      return v;
   endfunction

   // Drive one cycle of inputs at the falling edge, then wait past the
   // rising edge that consumes them
   task automatic applyStimulus(input logic rst, input logic vin, input logic [7:0] b);
      @(negedge clock);
      reset  = rst;
      dataIn = {b, vin};
      @(posedge clock);
      #1;
      if (dataOut[0] === 1'b1) valid_seen++;
   endtask

   // Compare symbol, valid, ready and error against expectations
   task automatic checkOutput(input string name, input logic ev, input logic [6:0] es,
                              input logic er, input logic ee);
      logic [9:0] got;
      logic [9:0] exp;
      got = {dataOut[7:1], dataOut[0], in_ready, proto_err};
      exp = {es, ev, er, ee};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got sym=%h v=%b rdy=%b err=%b, required sym=%h v=%b rdy=%b err=%b",
                  name, got[9:3], got[2], got[1], got[0], exp[9:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic checkState(input string name, input state_t exp);
      checks++;
      if (dut.State !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got state=%s, required %s", name, dut.State.name(), exp.name());
      end
   endtask

   initial begin
      vecs[0]  = mk(1, 0, 8'h00, 0, 7'h00, 1, 0, IDLE);
      vecs[1]  = mk(0, 1, 8'h37, 1, 7'h37, 1, 0, LIT);
      vecs[2]  = mk(0, 1, 8'hCB, 0, 7'h4B, 1, 0, HDR);
      vecs[3]  = mk(0, 1, 8'h03, 1, 7'h4B, 0, 0, RUN);
      vecs[4]  = mk(0, 0, 8'h00, 1, 7'h4B, 0, 0, RUN);
      vecs[5]  = mk(0, 0, 8'h00, 1, 7'h4B, 1, 0, RUN);
      vecs[6]  = mk(0, 0, 8'h00, 0, 7'h4B, 1, 0, IDLE);
      vecs[7]  = mk(0, 1, 8'h8E, 0, 7'h0E, 1, 0, HDR);
      vecs[8]  = mk(0, 1, 8'h00, 0, 7'h0E, 1, 1, IDLE);
      vecs[9]  = mk(0, 0, 8'h00, 0, 7'h0E, 1, 0, IDLE);
      vecs[10] = mk(0, 1, 8'hEF, 0, 7'h6F, 1, 0, HDR);
      vecs[11] = mk(0, 0, 8'h55, 0, 7'h6F, 1, 0, HDR);
      vecs[12] = mk(0, 0, 8'h55, 0, 7'h6F, 1, 0, HDR);
      vecs[13] = mk(0, 0, 8'h55, 0, 7'h6F, 1, 0, HDR);
      vecs[14] = mk(0, 0, 8'h55, 0, 7'h6F, 1, 0, HDR);
      vecs[15] = mk(0, 0, 8'h55, 0, 7'h6F, 1, 0, HDR);
      vecs[16] = mk(0, 1, 8'h01, 1, 7'h6F, 1, 0, LIT);
      vecs[17] = mk(0, 0, 8'h00, 0, 7'h6F, 1, 0, IDLE);
      vecs[18] = mk(0, 1, 8'h85, 0, 7'h05, 1, 0, HDR);
      vecs[19] = mk(0, 1, 8'h02, 1, 7'h05, 0, 0, RUN);
      vecs[20] = mk(0, 1, 8'h7F, 1, 7'h05, 1, 0, RUN);
      vecs[21] = mk(0, 1, 8'h7F, 1, 7'h7F, 1, 0, LIT);
      vecs[22] = mk(0, 1, 8'h00, 1, 7'h00, 1, 0, LIT);
      vecs[23] = mk(0, 0, 8'h00, 0, 7'h00, 1, 0, IDLE);
      vecs[24] = mk(0, 1, 8'h90, 0, 7'h10, 1, 0, HDR);
      vecs[25] = mk(1, 1, 8'h02, 0, 7'h00, 1, 0, IDLE);
      vecs[26] = mk(0, 0, 8'h00, 0, 7'h00, 1, 0, IDLE);

      for (int i = 0; i < 27; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].vin, vecs[i].b);
         checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es, vecs[i].er, vecs[i].ee);
         checkState($sformatf("vec%0d_state", i), vecs[i].st);
      end

      // Long runs: 255 then 15 copies of 0x08, one HDR gap between them.
      // A header byte is held on the bus throughout the first run and may
      // only be taken on its final cycle.
      applyStimulus(1, 0, 8'h00);
      checkOutput("lr_reset", 0, 7'h00, 1, 0);
      valid_seen = 0;
      applyStimulus(0, 1, 8'h88);
      checkOutput("lr_hdr1", 0, 7'h08, 1, 0);
      applyStimulus(0, 1, 8'hFF);
      checkOutput("lr_run1_255", 1, 7'h08, 0, 0);
      for (int k = 254; k >= 1; k--) begin
         applyStimulus(0, 1, 8'h88);
         checkOutput($sformatf("lr_run1_%0d", k), 1, 7'h08, (k == 1), 0);
      end
      applyStimulus(0, 1, 8'h88);
      checkOutput("lr_gap", 0, 7'h08, 1, 0);
      checkState("lr_gap_state", HDR);
      applyStimulus(0, 1, 8'h0F);
      checkOutput("lr_run2_15", 1, 7'h08, 0, 0);
      for (int k = 14; k >= 1; k--) begin
         applyStimulus(0, 0, 8'h00);
         checkOutput($sformatf("lr_run2_%0d", k), 1, 7'h08, (k == 1), 0);
      end
      applyStimulus(0, 0, 8'h00);
      checkOutput("lr_end", 0, 7'h08, 1, 0);
      checks++;
      if (valid_seen != 270) begin
         errors++;
         $display("[TB] FAIL lr_total: got %0d outputs, required 270", valid_seen);
      end

      // Reset while a 200-long run is at count 100
      applyStimulus(0, 1, 8'h81);
      checkOutput("rm_hdr", 0, 7'h01, 1, 0);
      applyStimulus(0, 1, 8'hC8);
      checkOutput("rm_run200", 1, 7'h01, 0, 0);
      for (int k = 199; k >= 100; k--) begin
         applyStimulus(0, 0, 8'h00);
      end
      checkOutput("rm_run100", 1, 7'h01, 0, 0);
      checks++;
      if (dut.count !== 8'd100) begin
         errors++;
         $display("[TB] FAIL rm_count100: got %0d, required 100", dut.count);
      end
      applyStimulus(1, 1, 8'h22);
      checkOutput("rm_reset", 0, 7'h00, 1, 0);
      checkState("rm_reset_state", IDLE);
      checks++;
      if (dut.count !== 8'd0) begin
         errors++;
         $display("[TB] FAIL rm_reset_count: got %0d, required 0", dut.count);
      end
      applyStimulus(0, 1, 8'h58);
      checkOutput("rm_lit58", 1, 7'h58, 1, 0);
      applyStimulus(0, 0, 8'h00);
      checkOutput("rm_idle", 0, 7'h58, 1, 0);

      // Ten literals back to back, no gaps, ready held high
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(0, 1, 8'(i));
         checkOutput($sformatf("lit_%0d", i), 1, 7'(i), 1, 0);
      end
      applyStimulus(0, 0, 8'h00);
      checkOutput("lit_idle", 0, 7'h0A, 1, 0);
      checkState("lit_idle_state", IDLE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
